// File: rtl/nand_sweep_checker.sv
// Exhaustive equivalence sweep: every N-bit input vector drives a behavioural
// NAND/NOR reduction and a cascade of 2-input gates, and the two are compared.
module nand_sweep_checker #(
    parameter int N    = 3,
    parameter int GATE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         fault_en,
    input  logic [N-1:0] fault_vec,
    output logic [N-1:0] vec,
    output logic         out_ref,
    output logic         out_dut,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err_vec,
    output logic         first_err_valid
);

    localparam logic [N-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] cnt;
    logic [N-1:1] stage_n;
    logic [N-2:0] run_acc;
    logic         chain;
    logic         fault_hit;
    logic         mism;
    logic [N:0]   err_next;

    function automatic logic g2(input logic a, input logic b);
        return (GATE == 0) ? ~(a & b) : ~(a | b);
    endfunction

    assign vec        = cnt;
    assign run_acc[0] = cnt[0];

    // Each stage gates the running AND/OR with the next input; feeding the
    // stage output into both inputs of a second gate restores the running
    // AND/OR for the following stage. The last stage output is the result.
    for (genvar k = 1; k < N; k++) begin : g_stage
        assign stage_n[k] = g2(run_acc[k-1], cnt[k]);
        if (k < N - 1) begin : g_acc
            assign run_acc[k] = g2(stage_n[k], stage_n[k]);
        end
    end

    assign chain     = stage_n[N-1];
    assign out_ref   = (GATE == 0) ? ~(&cnt) : ~(|cnt);
    assign fault_hit = fault_en && (cnt == fault_vec);
    assign out_dut   = chain ^ fault_hit;
    assign mism      = busy && (out_ref != out_dut);
    assign err_next  = err_cnt + {{N{1'b0}}, mism};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= SWEEP;
                        cnt             <= '0;
                        err_cnt         <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                    end
                end
                SWEEP: begin
                    err_cnt <= err_next;
                    if (mism && !first_err_valid) begin
                        first_err_vec   <= cnt;
                        first_err_valid <= 1'b1;
                    end
                    // The final vector is still compared on this edge; cnt then holds.
                    if (cnt == LAST_VEC) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_sweep_checker.sv
// Bench for nand_sweep_checker: directed and randomized sweeps on a 3-input NAND
// and an 8-input NOR instance, checked against a gate-truth model.
module tb_nand_sweep_checker;

    logic clk = 1'b0;
    logic rst_n;

    logic       start3, fe3;
    logic [2:0] fv3, vec3, fev3;
    logic       ref3, dut3, busy3, done3, pass3, fevalid3;
    logic [3:0] err3;

    logic       start8, fe8;
    logic [7:0] fv8, vec8, fev8;
    logic       ref8, dut8, busy8, done8, pass8, fevalid8;
    logic [8:0] err8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nand_sweep_checker #(.N(3), .GATE(0)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .fault_en(fe3), .fault_vec(fv3),
        .vec(vec3), .out_ref(ref3), .out_dut(dut3), .busy(busy3), .done(done3),
        .pass(pass3), .err_cnt(err3), .first_err_vec(fev3), .first_err_valid(fevalid3)
    );

    nand_sweep_checker #(.N(8), .GATE(1)) dut_n8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .fault_en(fe8), .fault_vec(fv8),
        .vec(vec8), .out_ref(ref8), .out_dut(dut8), .busy(busy8), .done(done8),
        .pass(pass8), .err_cnt(err8), .first_err_vec(fev8), .first_err_valid(fevalid8)
    );

    // Truth of the N-input gate: NAND is 0 only for all-ones, NOR is 1 only for zero.
    function automatic logic model_ref(input int v, input int n, input int gate);
        if (gate == 0) return (v != ((1 << n) - 1));
        return (v == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run3(input logic fe, input logic [2:0] fv, input bit mid_start);
        int exp_err;
        exp_err = fe ? 1 : 0;
        fe3 = fe;
        fv3 = fv;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("n3_vec", 32'(vec3), 32'(i));
            chk("n3_busy", 32'(busy3), 1);
            chk("n3_done", 32'(done3), 0);
            chk("n3_ref", 32'(ref3), 32'(model_ref(i, 3, 0)));
            chk("n3_dut", 32'(dut3), 32'(model_ref(i, 3, 0) ^ (fe && (int'(fv) == i))));
            if (i == 0) begin
                chk("n3_clr_err", 32'(err3), 0);
                chk("n3_clr_fevalid", 32'(fevalid3), 0);
            end
            if (mid_start && i == 3) start3 = 1'b1;
            @(posedge clk); #1;
            start3 = 1'b0;
        end
        chk("n3_done_end", 32'(done3), 1);
        chk("n3_busy_end", 32'(busy3), 0);
        chk("n3_vec_hold", 32'(vec3), 7);
        chk("n3_err_cnt", 32'(err3), 32'(exp_err));
        chk("n3_pass", 32'(pass3), 32'(exp_err == 0));
        chk("n3_fevalid", 32'(fevalid3), 32'(fe));
        if (fe) chk("n3_first_vec", 32'(fev3), 32'(fv));
        chk("n3_dut_in_done", 32'(dut3), 32'(model_ref(7, 3, 0) ^ (fe && fv == 3'd7)));
        @(posedge clk); #1;
        chk("n3_done_held", 32'(done3), 1);
        chk("n3_err_held", 32'(err3), 32'(exp_err));
        chk("n3_vec_held", 32'(vec3), 7);
    endtask

    task automatic run8(input logic fe, input logic [7:0] fv);
        int exp_err;
        int ref_ones;
        exp_err = fe ? 1 : 0;
        ref_ones = 0;
        fe8 = fe;
        fv8 = fv;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk("n8_vec", 32'(vec8), 32'(i));
            chk("n8_busy", 32'(busy8), 1);
            chk("n8_ref", 32'(ref8), 32'(model_ref(i, 8, 1)));
            chk("n8_dut", 32'(dut8), 32'(model_ref(i, 8, 1) ^ (fe && (int'(fv) == i))));
            ref_ones += int'(ref8);
            @(posedge clk); #1;
        end
        chk("n8_ref_ones", 32'(ref_ones), 1);
        chk("n8_done", 32'(done8), 1);
        chk("n8_vec_hold", 32'(vec8), 255);
        chk("n8_err_cnt", 32'(err8), 32'(exp_err));
        chk("n8_pass", 32'(pass8), 32'(exp_err == 0));
        chk("n8_fevalid", 32'(fevalid8), 32'(fe));
        if (fe) chk("n8_first_vec", 32'(fev8), 32'(fv));
    endtask

    initial begin
        logic       rfe;
        logic [2:0] rfv;
        bit         rmid;

        rst_n = 1'b0;
        start3 = 1'b0; fe3 = 1'b0; fv3 = '0;
        start8 = 1'b0; fe8 = 1'b0; fv8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy3), 0);
        chk("rst_done", 32'(done3), 0);
        chk("rst_pass", 32'(pass3), 0);
        chk("rst_err", 32'(err3), 0);
        chk("rst_fevalid", 32'(fevalid3), 0);
        chk("rst_vec", 32'(vec3), 0);
        chk("rst_busy8", 32'(busy8), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy3), 0);
        chk("idle_vec", 32'(vec3), 0);

        run3(1'b0, 3'd0, 1'b0);
        run3(1'b1, 3'd5, 1'b0);
        run3(1'b1, 3'd7, 1'b0);
        run3(1'b0, 3'd0, 1'b1);

        repeat (4) begin
            rfe  = 1'($urandom_range(0, 1));
            rfv  = 3'($urandom_range(0, 7));
            rmid = 1'($urandom_range(0, 1));
            run3(rfe, rfv, rmid);
        end

        // Reset in mid-sweep, asserted together with start.
        fe3 = 1'b1;
        fv3 = 3'd2;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_vec4", 32'(vec3), 4);
        chk("mid_err1", 32'(err3), 1);
        rst_n = 1'b0;
        start3 = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", 32'(busy3), 0);
        chk("mrst_vec", 32'(vec3), 0);
        chk("mrst_err", 32'(err3), 0);
        chk("mrst_done", 32'(done3), 0);
        chk("mrst_fevalid", 32'(fevalid3), 0);
        rst_n = 1'b1;
        start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy3), 0);
        chk("post_rst_vec", 32'(vec3), 0);
        chk("post_rst_done", 32'(done3), 0);
        fv3 = 3'd0;
        #1;
        chk("idle_fault_dut", 32'(dut3), 32'(model_ref(0, 3, 0) ^ 1'b1));
        fe3 = 1'b0;
        #1;
        chk("idle_nofault_dut", 32'(dut3), 32'(model_ref(0, 3, 0)));

        run8(1'b0, 8'd0);
        run8(1'b1, 8'($urandom_range(0, 255)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
